// File: rtl/topk_min_tracker.sv
// Keeps the K best (value, tag) pairs since the last clear in a sorted insertion array,
// and streams them best-first over a valid/ready drain port.
module topk_min_tracker #(
  parameter int VAL_W = 13,
  parameter int TAG_W = 32,
  parameter int K     = 4,
  parameter int MODE  = 0,
  localparam int RANK_W = (K > 1) ? $clog2(K) : 1,
  localparam int CNT_W  = $clog2(K + 1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VAL_W-1:0]   in_value,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               in_better,
  input  logic               drain_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VAL_W-1:0]   out_value,
  output logic [TAG_W-1:0]   out_tag,
  output logic [RANK_W-1:0]  out_rank,
  output logic               drain_done,
  output logic [CNT_W-1:0]   count,
  output logic               best_valid,
  output logic [VAL_W-1:0]   best_value,
  output logic [TAG_W-1:0]   best_tag
);

  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

  typedef enum logic {ACCUM, DRAIN} state_t;
  state_t state;

  logic [VAL_W-1:0] slot_val [K];
  logic [TAG_W-1:0] slot_tag [K];
  logic [K-1:0]     slot_vld;

  logic [VAL_W-1:0] prv_val [K];
  logic [TAG_W-1:0] prv_tag [K];
  logic [K-1:0]     prv_vld;
  logic [VAL_W-1:0] up_val [K];
  logic [TAG_W-1:0] up_tag [K];
  logic [K-1:0]     up_vld;
  logic [K-1:0]     b;
  logic [K-1:0]     ld_in;
  logic [K-1:0]     ld_prev;

  logic             ins_fire;
  logic             accept;
  logic [CNT_W-1:0] count_after_ins;

  assign ins_fire = in_valid & in_ready;
  assign accept   = out_valid & out_ready;

  // Strict compare: ties never displace an older entry, so equal values queue up behind it.
  for (genvar i = 0; i < K; i++) begin : g_slot
    if (MODE == 0) begin : g_min
      assign b[i] = ~slot_vld[i] | (in_value < slot_val[i]);
    end else begin : g_max
      assign b[i] = ~slot_vld[i] | (in_value > slot_val[i]);
    end

    if (i == 0) begin : g_head
      assign ld_in[i]   = b[i];
      assign ld_prev[i] = 1'b0;
      assign prv_val[i] = '0;
      assign prv_tag[i] = '0;
      assign prv_vld[i] = 1'b0;
    end else begin : g_body
      assign ld_in[i]   = b[i] & ~b[i-1];
      assign ld_prev[i] = b[i-1];
      assign prv_val[i] = slot_val[i-1];
      assign prv_tag[i] = slot_tag[i-1];
      assign prv_vld[i] = slot_vld[i-1];
    end

    if (i == K - 1) begin : g_tail
      assign up_val[i] = '0;
      assign up_tag[i] = '0;
      assign up_vld[i] = 1'b0;
    end else begin : g_mid
      assign up_val[i] = slot_val[i+1];
      assign up_tag[i] = slot_tag[i+1];
      assign up_vld[i] = slot_vld[i+1];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < K; i++) begin
        slot_val[i] <= '0;
        slot_tag[i] <= '0;
        slot_vld[i] <= 1'b0;
      end
    end else if (clear) begin
      for (int i = 0; i < K; i++) begin
        slot_val[i] <= '0;
        slot_tag[i] <= '0;
        slot_vld[i] <= 1'b0;
      end
    end else if (ins_fire) begin
      for (int i = 0; i < K; i++) begin
        if (ld_in[i]) begin
          slot_val[i] <= in_value;
          slot_tag[i] <= in_tag;
          slot_vld[i] <= 1'b1;
        end else if (ld_prev[i]) begin
          slot_val[i] <= prv_val[i];
          slot_tag[i] <= prv_tag[i];
          slot_vld[i] <= prv_vld[i];
        end
      end
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        slot_val[i] <= up_val[i];
        slot_tag[i] <= up_tag[i];
        slot_vld[i] <= up_vld[i];
      end
    end
  end

  assign count_after_ins = (ins_fire && count != K_CNT) ? count + CNT_W'(1) : count;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ACCUM;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_rank   <= '0;
      drain_done <= 1'b0;
      count      <= '0;
    end else if (clear) begin
      state      <= ACCUM;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_rank   <= '0;
      drain_done <= 1'b0;
      count      <= '0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        ACCUM: begin
          count <= count_after_ins;
          // A same-cycle sample is already counted, so it joins the drain.
          if (drain_req) begin
            if (count_after_ins != '0) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              drain_done <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state      <= ACCUM;
              in_ready   <= 1'b1;
              out_valid  <= 1'b0;
              out_rank   <= '0;
              drain_done <= 1'b1;
            end else begin
              out_rank <= out_rank + RANK_W'(1);
            end
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_better  = in_valid & in_ready & b[K-1];
  assign out_value  = out_valid ? slot_val[0] : '0;
  assign out_tag    = out_valid ? slot_tag[0] : '0;
  assign best_valid = slot_vld[0];
  assign best_value = slot_vld[0] ? slot_val[0] : '0;
  assign best_tag   = slot_vld[0] ? slot_tag[0] : '0;

endmodule

// File: tb/tb_topk_min_tracker.sv
// Drives three tracker configurations (K4 min, K2 max, K1 min) from one stimulus stream
// and compares every output against a queue-based reference model after each edge.
module tb_topk_min_tracker;
  localparam int VW = 13;
  localparam int TW = 32;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst, clear, in_valid, drain_req, out_ready;
  logic [VW-1:0] in_value;
  logic [TW-1:0] in_tag;

  logic a_in_ready, a_in_better, a_out_valid, a_drain_done, a_best_valid;
  logic [VW-1:0] a_out_value, a_best_value;
  logic [TW-1:0] a_out_tag, a_best_tag;
  logic [1:0] a_out_rank;
  logic [2:0] a_count;

  logic m_in_ready, m_in_better, m_out_valid, m_drain_done, m_best_valid;
  logic [VW-1:0] m_out_value, m_best_value;
  logic [TW-1:0] m_out_tag, m_best_tag;
  logic [0:0] m_out_rank;
  logic [1:0] m_count;

  logic s_in_ready, s_in_better, s_out_valid, s_drain_done, s_best_valid;
  logic [VW-1:0] s_out_value, s_best_value;
  logic [TW-1:0] s_out_tag, s_best_tag;
  logic [0:0] s_out_rank;
  logic [0:0] s_count;

  topk_min_tracker #(.VAL_W(VW), .TAG_W(TW), .K(4), .MODE(0)) u_a (
    .Clk(Clk), .Rst(Rst), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_value(in_value), .in_tag(in_tag), .in_better(a_in_better), .drain_req(drain_req),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_value(a_out_value), .out_tag(a_out_tag),
    .out_rank(a_out_rank), .drain_done(a_drain_done), .count(a_count), .best_valid(a_best_valid),
    .best_value(a_best_value), .best_tag(a_best_tag));

  topk_min_tracker #(.VAL_W(VW), .TAG_W(TW), .K(2), .MODE(1)) u_m (
    .Clk(Clk), .Rst(Rst), .clear(clear), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_value(in_value), .in_tag(in_tag), .in_better(m_in_better), .drain_req(drain_req),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_value(m_out_value), .out_tag(m_out_tag),
    .out_rank(m_out_rank), .drain_done(m_drain_done), .count(m_count), .best_valid(m_best_valid),
    .best_value(m_best_value), .best_tag(m_best_tag));

  topk_min_tracker #(.VAL_W(VW), .TAG_W(TW), .K(1), .MODE(0)) u_s (
    .Clk(Clk), .Rst(Rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_value(in_value), .in_tag(in_tag), .in_better(s_in_better), .drain_req(drain_req),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_value(s_out_value), .out_tag(s_out_tag),
    .out_rank(s_out_rank), .drain_done(s_drain_done), .count(s_count), .best_valid(s_best_valid),
    .best_value(s_best_value), .best_tag(s_best_tag));

  typedef struct { logic [VW-1:0] v; logic [TW-1:0] t; } ent_t;
  ent_t mq [3][$];
  int   mk    [3] = '{4, 2, 1};
  int   mmode [3] = '{0, 1, 0};
  bit   mdrain[3];
  int   mrank [3];
  bit   mdone [3];

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] got %0h want %0h", tag, i, obs, exp);
    end
  endtask

  function automatic bit better(input int i, input logic [VW-1:0] a, input logic [VW-1:0] b);
    return (mmode[i] != 0) ? (a > b) : (a < b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdrain[i] = 0;
      mrank[i]  = 0;
      mdone[i]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        mq[i].delete();
        mdrain[i] = 0;
        mrank[i]  = 0;
        mdone[i]  = 0;
      end else if (!mdrain[i]) begin
        mdone[i] = 0;
        if (in_valid) begin
          int pos;
          ent_t e;
          e.v = in_value;
          e.t = in_tag;
          pos = mq[i].size();
          for (int j = mq[i].size() - 1; j >= 0; j--)
            if (better(i, in_value, mq[i][j].v)) pos = j;
          if (pos < mk[i]) begin
            mq[i].insert(pos, e);
            if (mq[i].size() > mk[i]) void'(mq[i].pop_back());
          end
        end
        if (drain_req) begin
          if (mq[i].size() > 0) mdrain[i] = 1;
          else mdone[i] = 1;
        end
      end else begin
        mdone[i] = 0;
        if (out_ready) begin
          void'(mq[i].pop_front());
          mrank[i]++;
          if (mq[i].size() == 0) begin
            mdrain[i] = 0;
            mrank[i]  = 0;
            mdone[i]  = 1;
          end
        end
      end
    end
  endtask

  function automatic bit exp_better(input int i);
    if (!in_valid || mdrain[i]) return 0;
    if (mq[i].size() < mk[i]) return 1;
    return better(i, in_value, mq[i][mk[i]-1].v);
  endfunction

  task automatic check_inst(input int i, input logic rdy, input logic ov, input logic [63:0] oval,
                            input logic [63:0] otag, input logic [63:0] orank, input logic dd,
                            input logic [63:0] cnt, input logic bv, input logic [63:0] bval,
                            input logic [63:0] btag);
    bit ne;
    ne = mq[i].size() > 0;
    chk("in_ready",   i, rdy,   !mdrain[i]);
    chk("out_valid",  i, ov,    mdrain[i]);
    chk("out_value",  i, oval,  (mdrain[i] && ne) ? mq[i][0].v : '0);
    chk("out_tag",    i, otag,  (mdrain[i] && ne) ? mq[i][0].t : '0);
    chk("out_rank",   i, orank, mrank[i]);
    chk("drain_done", i, dd,    mdone[i]);
    chk("count",      i, cnt,   mq[i].size());
    chk("best_valid", i, bv,    ne);
    chk("best_value", i, bval,  ne ? mq[i][0].v : '0);
    chk("best_tag",   i, btag,  ne ? mq[i][0].t : '0);
  endtask

  task automatic check_all();
    check_inst(0, a_in_ready, a_out_valid, a_out_value, a_out_tag, a_out_rank, a_drain_done,
               a_count, a_best_valid, a_best_value, a_best_tag);
    check_inst(1, m_in_ready, m_out_valid, m_out_value, m_out_tag, m_out_rank, m_drain_done,
               m_count, m_best_valid, m_best_value, m_best_tag);
    check_inst(2, s_in_ready, s_out_valid, s_out_value, s_out_tag, s_out_rank, s_drain_done,
               s_count, s_best_valid, s_best_value, s_best_tag);
  endtask

  task automatic step();
    #1;
    chk("in_better", 0, a_in_better, exp_better(0));
    chk("in_better", 1, m_in_better, exp_better(1));
    chk("in_better", 2, s_in_better, exp_better(2));
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit iv, input int val, input int tg, input bit dr, input bit ordy,
                        input bit clr);
    in_valid  = iv;
    in_value  = VW'(val);
    in_tag    = TW'(tg);
    drain_req = dr;
    out_ready = ordy;
    clear     = clr;
  endtask

  task automatic cyc(input bit iv, input int val, input int tg, input bit dr, input bit ordy,
                     input bit clr);
    set_in(iv, val, tg, dr, ordy, clr);
    step();
  endtask

  task automatic finish_drains();
    for (int n = 0; n < 12 && (mdrain[0] || mdrain[1] || mdrain[2]); n++) cyc(0, 0, 0, 0, 1, 0);
    chk("drain_bound", 0, mdrain[0] || mdrain[1] || mdrain[2], 0);
  endtask

  int exp_v [4] = '{3, 5, 5, 7};
  int exp_t [4] = '{'hA4, 'hA1, 'hB, 'hA2};

  initial begin
    Rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all();
    chk("rst_in_ready", 0, a_in_ready, 1);
    Rst = 1'b0;

    // K=4 min: ties keep arrival order, 10 falls off the end
    cyc(1, 10, 'hA0, 0, 0, 0);
    cyc(1, 5,  'hA1, 0, 0, 0);
    cyc(1, 7,  'hA2, 0, 0, 0);
    cyc(1, 5,  'hB,  0, 0, 0);
    cyc(1, 3,  'hA4, 0, 0, 0);
    chk("k4_count", 0, a_count, 4);
    chk("k4_best", 0, a_best_value, 3);
    chk("k4_best_tag", 0, a_best_tag, 'hA4);
    set_in(1, 8, 'hA5, 0, 0, 0);
    #1;
    chk("k4_better8", 0, a_in_better, 0);
    step();

    cyc(0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      chk("stall_value", 0, a_out_value, 3);
      cyc(0, 0, 0, 0, 0, 0);
    end
    for (int r = 0; r < 4; r++) begin
      chk("drain_value", r, a_out_value, exp_v[r]);
      chk("drain_tag", r, a_out_tag, exp_t[r]);
      chk("drain_rank", r, a_out_rank, r);
      chk("drain_early_done", r, a_drain_done, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    chk("drain_done", 0, a_drain_done, 1);
    chk("drain_count", 0, a_count, 0);
    chk("drain_ready", 0, a_in_ready, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_done_pulse", 0, a_drain_done, 0);

    // K=2 max: a sentinel-valued zero is still accepted
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 'hC0, 0, 0, 0);
    chk("max_sentinel_cnt", 1, m_count, 1);
    chk("max_sentinel_best", 1, m_best_valid, 1);
    cyc(1, 'h1FFF, 'hC1, 0, 0, 0);
    cyc(1, 'h0005, 'hC2, 0, 0, 0);
    chk("max_best", 1, m_best_value, 'h1FFF);
    cyc(0, 0, 0, 1, 1, 0);
    chk("max_r0", 1, m_out_value, 'h1FFF);
    cyc(0, 0, 0, 0, 1, 0);
    chk("max_r1", 1, m_out_value, 'h0005);
    finish_drains();

    // Empty drain, then drain_req together with an insert
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("empty_valid", 0, a_out_valid, 0);
    chk("empty_done", 0, a_drain_done, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("empty_done_once", 0, a_drain_done, 0);
    cyc(1, 9, 'hD9, 1, 0, 0);
    chk("join_valid", 0, a_out_valid, 1);
    chk("join_value", 0, a_out_value, 9);
    cyc(0, 0, 0, 0, 1, 0);
    chk("join_done", 0, a_drain_done, 1);
    finish_drains();

    // Async reset in the middle of a drain
    cyc(1, 20, 1, 0, 0, 0);
    cyc(1, 21, 2, 0, 0, 0);
    cyc(1, 22, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("mid_rank", 0, a_out_rank, 2);
    set_in(0, 0, 0, 0, 0, 0);
    #2 Rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("arst_value", 0, a_out_value, 0);
    chk("arst_ready", 0, a_in_ready, 1);
    #1 Rst = 1'b0;

    cyc(1, 30, 1, 0, 0, 0);
    cyc(1, 31, 2, 0, 0, 1);
    chk("clear_drop", 0, a_count, 0);

    // K=1: behaves like the single min register
    cyc(1, 4, 'h44, 0, 0, 0);
    chk("k1_4", 2, s_best_value, 4);
    set_in(1, 6, 'h66, 0, 0, 0);
    #1;
    chk("k1_better6", 2, s_in_better, 0);
    step();
    chk("k1_6", 2, s_best_value, 4);
    set_in(1, 2, 'h22, 0, 0, 0);
    #1;
    chk("k1_better2", 2, s_in_better, 1);
    step();
    chk("k1_2", 2, s_best_value, 2);
    chk("k1_2_tag", 2, s_best_tag, 'h22);

    // Randomized traffic with small values to force ties
    for (int n = 0; n < 600; n++) begin
      int v;
      if ($urandom_range(0, 5) == 0) v = ($urandom_range(0, 1) != 0) ? 'h1FFF : 0;
      else v = $urandom_range(0, 12);
      cyc($urandom_range(0, 1), v, $urandom, $urandom_range(0, 12) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 80) == 0);
    end
    finish_drains();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/topk_min_tracker.md
Name: topk_min_tracker

Overview:
- Parametrised successor to the single-entry min register: keeps the K best (value, tag) pairs seen since the last clear, sorted best-first.
- Each entry is kept in a sorted insertion register array.
- Selects minimum or maximum ordering by parameter.
- Provides a valid/ready drain port that streams the K results in rank order; used by the search and compare stages to collect candidate indices.

Parameters:
VAL_W, 13, width of compared value
TAG_W, 32, width of tag carried with each value
K, 4, number of entries kept (K >= 1)
MODE, 0, 0 = keep smallest (min), 1 = keep largest (max); unsigned compare

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  asynchronous active-high reset
clear  in  1  synchronous empty of all entries, returns to ACCUM
in_valid  in  1  sample present
in_ready  out  1  high in ACCUM
in_value  in  VAL_W  sample value
in_tag  in  TAG_W  sample tag
in_better  out  1  combinational: in_value would be inserted now
drain_req  in  1  pulse: start streaming results
out_valid  out  1  drain entry present
out_ready  in  1  consumer accepts drain entry
out_value  out  VAL_W  value at rank out_rank
out_tag  out  TAG_W  tag at rank out_rank
out_rank  out  $clog2(K) (min 1)  rank of current drain entry, 0 = best
drain_done  out  1  one-cycle pulse after last entry accepted
count  out  $clog2(K+1)  occupied entries
best_valid  out  1  slot 0 occupied
best_value  out  VAL_W  slot 0 value
best_tag  out  TAG_W  slot 0 tag

Behaviour:
- Storage: slots 0..K-1, each holds {valid, tag, value}.
  - Occupied slots form a prefix, sorted best-first.
  - An empty slot is worse than any input, so a value equal to the sentinel (all-ones, or zero in max mode) still inserts.
- "Better":
  - MODE 0: in < slot.
  - MODE 1: in > slot.
  - Strict: on a tie the older entry ranks ahead and the new entry goes after all equal entries.
- Insertion happens on in_valid & in_ready; result is visible on outputs the next cycle.
  - b[i] = in better than slot i, or slot i empty.
  - Slot i loads the input when b[i] & (i==0 | !b[i-1]).
  - Slot i loads slot i-1 when b[i-1].
  - Otherwise slot i holds.
  - Slot K-1 contents are discarded when it is shifted out.
  - count increments, saturating at K.
  - in_better = b[K-1], combinational, valid only while in_ready = 1.
- State machine, two states, reset to ACCUM:
  - ACCUM: in_ready=1, out_valid=0.
    - drain_req with count>0 (count taken after any same-cycle insert) -> DRAIN.
    - drain_req with count==0 and no same-cycle insert -> stay in ACCUM, drain_done pulses next cycle.
    - in_valid together with drain_req: the sample is inserted first and is included in the drain.
  - DRAIN: in_ready=0 and in_valid is ignored; out_valid=1 and out_value/out_tag come from slot 0.
    - On out_ready, all slots shift toward slot 0, slot K-1 is emptied, count decrements and out_rank increments.
    - When the entry accepted has count==1: next state ACCUM, out_rank returns to 0, drain_done=1 for one cycle.
    - out_ready low: the outputs hold stable.
    - drain_req is ignored in DRAIN.
- clear (any state): all slots empty, count=0, out_rank=0, state ACCUM, drain_done=0; overrides a same-cycle insert or accept.
- Rst (asynchronous, any time, including mid-drain):
  - All slots empty and zeroed; state ACCUM.
  - Outputs: in_ready=1, all other outputs 0; out_value/out_tag/best_* = 0.
- best_* mirror slot 0 in every state; best_value/best_tag = 0 when empty.
- K=1 reproduces the single-register behaviour, plus the drain port.

Test Plan:
- K=4, MODE 0: insert 10,5,7,5(tag 0xB),3 with tags 0xA0..0xA4 (the second 5 uses 0xB) -> slots 3/0xA4, 5/0xA1, 5/0xB, 7/0xA2; count=4; 10 evicted; in_better=0 for a following 8.
- Drain after the above with out_ready held low 3 cycles, then high -> out_value holds 3 while stalled; then streams 3,5,5,7 with out_rank 0..3; drain_done pulses the cycle after 7 is accepted; count=0; in_ready=1.
- MODE 1, K=2: insert 0x0000, 0x1FFF, 0x0005 -> slots 0x1FFF, 0x0005; sentinel-valued 0x0000 was accepted, then evicted.
- drain_req with count==0 -> no out_valid; drain_done high exactly 1 cycle later. drain_req together with in_valid=9 on empty -> drains single entry 9.
- Assert Rst mid-drain after rank 1 -> outputs 0 immediately (asynchronous), in_ready=1. clear with in_valid=1 -> count=0 next cycle, sample dropped.
- K=1, MODE 0: insert 4, then 6, then 2 -> best_value 4, 4, 2; in_better=0 for 6 and 1 for 2.
